// File: rtl/lpc_sniffer_pkg.sv
// Shared types and constants for the LPC sniffer record path.
package lpc_sniffer_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned REC_W     = 48;
    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned IDX_W     = 3;

    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

    localparam int unsigned ADDR_MSB    = 47;
    localparam int unsigned ADDR_LSB    = 16;
    localparam int unsigned DATA_MSB    = 15;
    localparam int unsigned DATA_LSB    = 8;
    localparam int unsigned TIMEOUT_BIT = 4;
    localparam int unsigned CYCDIR_MSB  = 3;
    localparam int unsigned CYCDIR_LSB  = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
        logic [2:0]  rsvd;
        logic        sync_timeout;
        logic [3:0]  cyctype_dir;
    } lpc_record_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        GAP
    } framer_state_e;

endpackage

// File: rtl/frame_byte_mux.sv
// Selects the frame byte for the current index: SYNC, payload MSB first, CHK.
module frame_byte_mux
    import lpc_sniffer_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC = SYNC_BYTE
) (
    input  logic [IDX_W-1:0]  index_i,
    input  logic [REC_W-1:0]  rec_i,
    input  logic [BYTE_W-1:0] chk_i,
    output logic [BYTE_W-1:0] tx_byte_c
);

    always_comb begin
        tx_byte_c = SYNC;
        case (index_i)
            3'd1:    tx_byte_c = rec_i[47:40];
            3'd2:    tx_byte_c = rec_i[39:32];
            3'd3:    tx_byte_c = rec_i[31:24];
            3'd4:    tx_byte_c = rec_i[23:16];
            3'd5:    tx_byte_c = rec_i[15:8];
            3'd6:    tx_byte_c = rec_i[7:0];
            3'd7:    tx_byte_c = chk_i;
            default: tx_byte_c = SYNC;
        endcase
    end

endmodule

// File: rtl/lpc_record_framer.sv
// Pops one 48-bit record from the ring buffer and emits it as an 8-byte
// SYNC/payload/XOR frame, one byte per strobe with a gap cycle between strobes.
module lpc_record_framer
    import lpc_sniffer_pkg::*;
#(
    parameter int unsigned       DW           = 48,
    parameter logic [7:0]        SYNC         = 8'hA5,
    parameter int unsigned       READ_LATENCY = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          read_empty,
    input  logic [DW-1:0] read_data,
    output logic          read_clock_enable,
    input  logic          uart_ready,
    output logic          uart_clock_enable,
    output logic [7:0]    uart_data,
    output logic          busy
);

    localparam int unsigned         LAT_W    = 2;
    localparam logic [LAT_W-1:0]    LAT_LAST = LAT_W'(READ_LATENCY - 1);

    framer_state_e      state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BYTE_W-1:0]  chk_q, chk_d;
    lpc_record_t        rec_q, rec_d;
    logic               cap_q, cap_d;
    logic [LAT_W-1:0]   wait_q, wait_d;
    logic               rce_q, rce_d;
    logic               uce_q, uce_d;
    logic [BYTE_W-1:0]  udata_q, udata_d;
    logic               busy_q, busy_d;
    logic [BYTE_W-1:0]  tx_byte_c;

    frame_byte_mux #(
        .SYNC      (SYNC)
    ) u_byte_mux (
        .index_i   (idx_q),
        .rec_i     (rec_q),
        .chk_i     (chk_q),
        .tx_byte_c (tx_byte_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        rec_d   = rec_q;
        cap_d   = 1'b0;
        wait_d  = wait_q;
        rce_d   = 1'b0;
        uce_d   = 1'b0;
        udata_d = udata_q;

        // read_data is valid in the first SEND cycle; SYNC goes out without it.
        if (cap_q) begin
            rec_d = lpc_record_t'(read_data);
        end

        case (state_q)
            IDLE: begin
                if (!read_empty) begin
                    rce_d   = 1'b1;
                    wait_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (wait_q == LAT_LAST) begin
                    cap_d   = 1'b1;
                    chk_d   = '0;
                    idx_d   = '0;
                    state_d = SEND;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            SEND: begin
                if (uart_ready) begin
                    uce_d   = 1'b1;
                    udata_d = tx_byte_c;
                    if (idx_q != 3'd0 && idx_q != 3'd7) begin
                        chk_d = chk_q ^ tx_byte_c;
                    end
                    state_d = GAP;
                end
            end
            GAP: begin
                if (idx_q == 3'd7) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            chk_q   <= '0;
            rec_q   <= '0;
            cap_q   <= 1'b0;
            wait_q  <= '0;
            rce_q   <= 1'b0;
            uce_q   <= 1'b0;
            udata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            rec_q   <= rec_d;
            cap_q   <= cap_d;
            wait_q  <= wait_d;
            rce_q   <= rce_d;
            uce_q   <= uce_d;
            udata_q <= udata_d;
            busy_q  <= busy_d;
        end
    end

    assign read_clock_enable = rce_q;
    assign uart_clock_enable = uce_q;
    assign uart_data         = udata_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_lpc_record_framer.sv
// Bench for lpc_record_framer: lane 0 at read latency 1, lane 1 at latency 2,
// each fed by a small ring-buffer model and checked against a byte scoreboard.
module tb_lpc_record_framer;

    localparam logic [47:0] GARB = 48'h5A5A_C3C3_0F0F;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        uart_ready = 1'b1;
    logic        read_empty [2] = '{1'b1, 1'b1};
    logic [47:0] read_data [2];
    logic        rce [2];
    logic        uce [2];
    logic [7:0]  udata [2];
    logic        busy [2];
    logic [7:0]  last_byte [2];

    logic [47:0] rec_q [2][$];
    logic [7:0]  exp_q [2][$];

    int vectors = 0;
    int miscompares = 0;
    int pops [2] = '{0, 0};
    int strobes [2] = '{0, 0};

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected frame: SYNC, six payload bytes MSB first, XOR of the payload.
    task automatic push(input int lane, input logic [47:0] r);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h00;
        rec_q[lane].push_back(r);
        exp_q[lane].push_back(8'hA5);
        for (int i = 5; i >= 0; i--) begin
            b = r[i*8 +: 8];
            c = c ^ b;
            exp_q[lane].push_back(b);
        end
        exp_q[lane].push_back(c);
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic drive();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_done(input int lane, input int budget, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (exp_q[lane].size() == 0 && rec_q[lane].size() == 0 && !busy[lane]) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_strobes(input int lane, input int target, input int budget, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (strobes[lane] >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = g + 1;
        logic        uce_prev = 1'b0;
        logic        busy_prev = 1'b0;
        logic        ready_prev = 1'b1;
        logic        pop_req = 1'b0;
        int          dly = 0;
        logic [47:0] hold = '0;
        logic [47:0] nxt;

        lpc_record_framer #(
            .DW                (48),
            .SYNC              (8'hA5),
            .READ_LATENCY      (LAT)
        ) u_dut (
            .clock             (clock),
            .reset             (reset),
            .read_empty        (read_empty[g]),
            .read_data         (read_data[g]),
            .read_clock_enable (rce[g]),
            .uart_ready        (uart_ready),
            .uart_clock_enable (uce[g]),
            .uart_data         (udata[g]),
            .busy              (busy[g])
        );

        always @(negedge clock) read_empty[g] <= (rec_q[g].size() == 0);

        // Ring buffer: read_data valid only LAT cycles after the pop cycle.
        always @(posedge clock) begin
            nxt = GARB;
            if (dly > 0) begin
                dly = dly - 1;
                if (dly == 0) nxt = hold;
            end
            if (pop_req && rec_q[g].size() != 0) begin
                hold = rec_q[g].pop_front();
                dly  = LAT - 1;
                if (LAT == 1) nxt = hold;
            end
            read_data[g] <= nxt;
        end

        always @(negedge clock) begin
            pop_req = rce[g] && !reset;
            if (reset) begin
                uce_prev  = 1'b0;
                busy_prev = 1'b0;
            end else begin
                if (uce[g]) begin
                    strobes[g]++;
                    chk("strobe_spacing", 64'(uce_prev), 64'd0);
                    chk("strobe_needs_ready", 64'(ready_prev), 64'd1);
                    chk("byte_expected", 64'(exp_q[g].size() != 0), 64'd1);
                    if (exp_q[g].size() != 0) chk("frame_byte", 64'(udata[g]), 64'(exp_q[g].pop_front()));
                    last_byte[g] = udata[g];
                end
                if (rce[g]) begin
                    pops[g]++;
                    chk("pop_while_busy", 64'(busy_prev), 64'd0);
                end
                uce_prev  = uce[g];
                busy_prev = busy[g];
            end
            ready_prev = uart_ready;
        end
    end

    initial begin
        int n, base_s, base_p, s0;
        int bs [2];
        int bp [2];

        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        step();
        for (int l = 0; l < 2; l++) begin
            chk("rst_rce", 64'(rce[l]), 64'd0);
            chk("rst_uce", 64'(uce[l]), 64'd0);
            chk("rst_udata", 64'(udata[l]), 64'd0);
            chk("rst_busy", 64'(busy[l]), 64'd0);
        end
        drive();
        reset = 1'b0;

        // Single record, ready held high.
        drive();
        base_s = strobes[0];
        base_p = pops[0];
        push(0, 48'h0000_0080_3402);
        step();
        chk("pop_early", 64'(rce[0]), 64'd0);
        step();
        chk("pop_latency", 64'(rce[0]), 64'd1);
        n = 0;
        while (!uce[0] && n < 20) begin step(); n++; end
        chk("sync_latency_l1", 64'(n), 64'd2);
        n = 0;
        while (strobes[0] - base_s < 8 && n < 40) begin step(); n++; end
        chk("frame_span", 64'(n), 64'd14);
        chk("busy_in_last_gap", 64'(busy[0]), 64'd1);
        step();
        chk("busy_fall", 64'(busy[0]), 64'd0);
        chk("t1_pops", 64'(pops[0] - base_p), 64'd1);
        chk("t1_chk", 64'(last_byte[0]), 64'hB6);

        // uart_ready stall before byte 3.
        drive();
        base_s = strobes[0];
        push(0, 48'h1234_5678_9ABC);
        wait_strobes(0, base_s + 3, 40, "t2_pre_timeout");
        drive();
        uart_ready = 1'b0;
        s0 = strobes[0];
        repeat (5) begin
            step();
            chk("stall_hold_data", 64'(udata[0]), 64'(last_byte[0]));
        end
        chk("stall_no_strobe", 64'(strobes[0] - s0), 64'd0);
        drive();
        uart_ready = 1'b1;
        wait_done(0, 60, "t2_timeout");
        chk("t2_strobes", 64'(strobes[0] - base_s), 64'd8);

        // Three records back to back, including an all-zero record.
        drive();
        base_s = strobes[0];
        base_p = pops[0];
        push(0, 48'hDEAD_BEEF_0011);
        push(0, 48'h0000_0000_0000);
        push(0, 48'hFEDC_BA98_7654);
        wait_done(0, 200, "t3_timeout");
        chk("t3_pops", 64'(pops[0] - base_p), 64'd3);
        chk("t3_strobes", 64'(strobes[0] - base_s), 64'd24);

        // Read latency 2 on lane 1.
        drive();
        push(1, 48'hFFFF_FFFF_FF1F);
        step();
        chk("l2_pop_early", 64'(rce[1]), 64'd0);
        step();
        chk("l2_pop_latency", 64'(rce[1]), 64'd1);
        n = 0;
        while (!uce[1] && n < 20) begin step(); n++; end
        chk("sync_latency_l2", 64'(n), 64'd3);
        wait_done(1, 60, "t4_timeout");
        chk("l2_chk", 64'(last_byte[1]), 64'hE0);
        chk("l2_pops", 64'(pops[1]), 64'd1);
        chk("l2_strobes", 64'(strobes[1]), 64'd8);

        // Reset after the 4th strobe; the popped record is lost.
        drive();
        base_s = strobes[0];
        base_p = pops[0];
        push(0, 48'h1111_2222_3333);
        push(0, 48'h0102_0304_0506);
        wait_strobes(0, base_s + 4, 40, "t5_pre_timeout");
        reset = 1'b1;
        #1;
        chk("arst_uce", 64'(uce[0]), 64'd0);
        chk("arst_busy", 64'(busy[0]), 64'd0);
        chk("arst_udata", 64'(udata[0]), 64'd0);
        chk("arst_rce", 64'(rce[0]), 64'd0);
        chk("t5_pending", 64'(exp_q[0].size()), 64'd12);
        repeat (4) void'(exp_q[0].pop_front());
        drive();
        reset = 1'b0;
        wait_done(0, 100, "t5_timeout");
        chk("t5_pops", 64'(pops[0] - base_p), 64'd2);
        chk("t5_strobes", 64'(strobes[0] - base_s), 64'd12);

        // Empty ring buffer for 100 cycles.
        for (int l = 0; l < 2; l++) begin
            bs[l] = strobes[l];
            bp[l] = pops[l];
        end
        repeat (100) step();
        for (int l = 0; l < 2; l++) begin
            chk("idle_pops", 64'(pops[l] - bp[l]), 64'd0);
            chk("idle_strobes", 64'(strobes[l] - bs[l]), 64'd0);
            chk("idle_busy", 64'(busy[l]), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
